bram_dp: RTL and testbench
==========================

Name: bram_dp

Overview:
- True dual-port synchronous block RAM with two independent read/write ports (A and B) sharing one storage array.
- Used as the track buffer between the SD/IO DMA side (port A) and the disk-controller side (port B), e.g. 8-bit x 8192 for a 0x1A00-byte floppy track.
- Both ports run in a single clock domain.
- Reads are registered with 1-cycle latency.

Parameters:
- width_a, 8, data width in bits of both ports (must be >= 1).
- widthad_a, 13, address width of both ports; depth = 2**widthad_a words.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- address_a  in  widthad_a  port A word address.
- data_a  in  width_a  port A write data.
- wren_a  in  1  port A write enable.
- enable_a  in  1  port A clock enable; gates both read and write.
- q_a  out  width_a  port A registered read data.
- address_b  in  widthad_a  port B word address.
- data_b  in  width_a  port B write data.
- wren_b  in  1  port B write enable.
- enable_b  in  1  port B clock enable; gates both read and write.
- q_b  out  width_a  port B registered read data.

Behaviour:
- Storage: 2**widthad_a words of width_a bits. Contents power up to all zeros. Reset does not clear storage.
- Reset: when reset=1 at a clock edge, q_a and q_b become 0 and no write occurs on either port. Reset dominates enable and wren.
- Port X write (X = a or b): at an edge with reset=0, enable_x=1 and wren_x=1, mem[address_x] <= data_x.
- Port X read: at an edge with reset=0 and enable_x=1, q_x <= mem[address_x].
  - This happens regardless of wren_x.
  - Data appears on q_x one cycle after the address is presented.
- enable_x=0: port X neither reads nor writes; q_x holds its previous value.
- Same-port read-during-write (read-first): when port X writes address N, q_x returns the OLD contents of N on that cycle. New data is visible on the next read of N.
- Cross-port read-during-write: when one port writes N while the other reads N in the same cycle, the reader gets the OLD contents. New data is visible from the following cycle.
- Simultaneous writes to the same address by both ports: port A wins; port B's write to that address is discarded. Writes to different addresses both complete.
- Addresses are used in full; there is no wrap or out-of-range case since depth equals 2**widthad_a.
- No combinational path from any input to q_a or q_b.
- Output is synthesizable as an inferred FPGA block RAM. No handshakes and no busy states.

Test Plan:
1. Reset sanity: assert reset for 2 cycles with wren_a=wren_b=1 and data 0xFF at address 0x0000. Then q_a=q_b=0, and a later read of 0x0000 returns 0x00 (write was suppressed).
2. Port A write/port B read: A writes 0x5A to 0x1234. Next cycle B reads 0x1234; q_b=0x5A one cycle after the address is applied. Also check B reading 0x1FFF gives 0x00 (power-up value).
3. Read-first: mem[0x0010]=0x11, then A writes 0x22 to 0x0010 with enable_a=1. That cycle q_a=0x11; a subsequent A read gives 0x22.
4. Cross-port collision: mem[0x0100]=0x33. A reads 0x0100 while B writes 0x44 there in the same cycle. q_a=0x33; the next A read gives 0x44.
5. Dual-write conflict: A writes 0xAA and B writes 0xBB to 0x0200 in the same cycle. A later read gives 0xAA. Separately, A writes 0x01 to 0x0300 and B writes 0x02 to 0x0301 simultaneously; both are stored.
6. Enable gating: q_b=0x5A, then enable_b=0 with wren_b=1, data_b=0x77, address 0x1234. q_b stays 0x5A and mem[0x1234] is unchanged (still 0x5A).

Source files
------------

// File: rtl/bram_dp.sv
// bram_dp: true dual-port synchronous block RAM, single clock domain.
//
// Two independent read/write ports (A and B) share one storage array of
// 2**widthad_a words, each width_a bits wide. Typical use is the track
// buffer between the SD/IO DMA side (port A) and the disk-controller side
// (port B).
//
// Ports:
//   clk        - single clock, all state changes on its rising edge
//   reset      - synchronous, active-high; clears q_a/q_b and blocks writes
//   address_a  - port A word address
//   data_a     - port A write data
//   wren_a     - port A write enable
//   enable_a   - port A clock enable (gates read and write)
//   q_a        - port A registered read data (1-cycle latency)
//   address_b  - port B word address
//   data_b     - port B write data
//   wren_b     - port B write enable
//   enable_b   - port B clock enable (gates read and write)
//   q_b        - port B registered read data (1-cycle latency)
//
// Both ports are read-first: a read and a write of the same word in the same
// cycle, on either port, return the old contents. When both ports write the
// same word in the same cycle, port A's data is kept.

module bram_dp #(
    parameter int width_a   = 8,
    parameter int widthad_a = 13
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [widthad_a-1:0] address_a,
    input  logic [width_a-1:0]   data_a,
    input  logic                 wren_a,
    input  logic                 enable_a,
    output logic [width_a-1:0]   q_a,
    input  logic [widthad_a-1:0] address_b,
    input  logic [width_a-1:0]   data_b,
    input  logic                 wren_b,
    input  logic                 enable_b,
    output logic [width_a-1:0]   q_b
);

    localparam int depth = 2 ** widthad_a;

    // Storage powers up cleared; reset never touches it.
    logic [width_a-1:0] mem [depth] = '{default: '0};

    logic write_a;
    logic write_b;

    // Port B's write is dropped when port A writes the same word this cycle,
    // so port A wins a same-address collision.
    always_comb begin
        write_a = 1'b0;
        write_b = 1'b0;
        if (!reset) begin
            write_a = enable_a & wren_a;
            write_b = enable_b & wren_b & ~(write_a && (address_a == address_b));
        end
    end

    // Read registers: sampled from the array before this edge's writes land.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_a <= '0;
            q_b <= '0;
        end else begin
            if (enable_a) begin
                q_a <= mem[address_a];
            end
            if (enable_b) begin
                q_b <= mem[address_b];
            end
        end
    end

    // Array update.
    always_ff @(posedge clk) begin
        if (write_a) begin
            mem[address_a] <= data_a;
        end
        if (write_b) begin
            mem[address_b] <= data_b;
        end
    end

endmodule

// File: tb/tb_bram_dp.sv
// tb_bram_dp: directed testbench for bram_dp (8-bit x 8192).
//
// Inputs are changed 1 ns after a rising edge and outputs are sampled at the
// same point, so each tick() covers exactly one active edge.

module tb_bram_dp;

    localparam int W  = 8;
    localparam int AW = 13;

    logic          clk;
    logic          reset;
    logic [AW-1:0] address_a;
    logic [W-1:0]  data_a;
    logic          wren_a;
    logic          enable_a;
    logic [W-1:0]  q_a;
    logic [AW-1:0] address_b;
    logic [W-1:0]  data_b;
    logic          wren_b;
    logic          enable_b;
    logic [W-1:0]  q_b;

    int checks = 0;
    int errors = 0;

    bram_dp #(
        .width_a   (W),
        .widthad_a (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address_a (address_a),
        .data_a    (data_a),
        .wren_a    (wren_a),
        .enable_a  (enable_a),
        .q_a       (q_a),
        .address_b (address_b),
        .data_b    (data_b),
        .wren_b    (wren_b),
        .enable_b  (enable_b),
        .q_b       (q_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] actual,
                         input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic en, input logic wr, input logic [AW-1:0] addr,
                         input logic [W-1:0] d);
        enable_a  = en;
        wren_a    = wr;
        address_a = addr;
        data_a    = d;
    endtask

    task automatic set_b(input logic en, input logic wr, input logic [AW-1:0] addr,
                         input logic [W-1:0] d);
        enable_b  = en;
        wren_b    = wr;
        address_b = addr;
        data_b    = d;
    endtask

    initial begin
        // 1. Reset with both ports trying to write 0xFF to 0x0000.
        reset = 1'b1;
        set_a(1'b1, 1'b1, 13'h0000, 8'hFF);
        set_b(1'b1, 1'b1, 13'h0000, 8'hFF);
        tick();
        tick();
        check("reset_q_a", q_a, 8'h00);
        check("reset_q_b", q_b, 8'h00);
        reset = 1'b0;
        set_a(1'b1, 1'b0, 13'h0000, 8'h00);
        set_b(1'b1, 1'b0, 13'h0000, 8'h00);
        tick();
        check("reset_nowrite_a", q_a, 8'h00);
        check("reset_nowrite_b", q_b, 8'h00);

        // 2. A writes 0x5A to 0x1234, B reads it back; B reads untouched 0x1FFF.
        set_a(1'b1, 1'b1, 13'h1234, 8'h5A);
        set_b(1'b0, 1'b0, 13'h0000, 8'h00);
        tick();
        set_a(1'b0, 1'b0, 13'h0000, 8'h00);
        set_b(1'b1, 1'b0, 13'h1234, 8'h00);
        tick();
        check("b_reads_a_write", q_b, 8'h5A);
        set_b(1'b1, 1'b0, 13'h1FFF, 8'h00);
        tick();
        check("b_powerup_1fff", q_b, 8'h00);

        // 3. Same-port read-first at 0x0010.
        set_b(1'b0, 1'b0, 13'h0000, 8'h00);
        set_a(1'b1, 1'b1, 13'h0010, 8'h11);
        tick();
        set_a(1'b1, 1'b1, 13'h0010, 8'h22);
        tick();
        check("a_read_first_old", q_a, 8'h11);
        set_a(1'b1, 1'b0, 13'h0010, 8'h00);
        tick();
        check("a_read_first_new", q_a, 8'h22);

        // 4. Cross-port collision at 0x0100: A reads while B writes.
        set_a(1'b1, 1'b1, 13'h0100, 8'h33);
        tick();
        set_a(1'b1, 1'b0, 13'h0100, 8'h00);
        set_b(1'b1, 1'b1, 13'h0100, 8'h44);
        tick();
        check("cross_a_old", q_a, 8'h33);
        check("cross_b_read_first", q_b, 8'h33);
        set_b(1'b0, 1'b0, 13'h0000, 8'h00);
        tick();
        check("cross_a_new", q_a, 8'h44);

        // 5. Dual write to 0x0200 (A wins), then writes to different words.
        set_a(1'b1, 1'b1, 13'h0200, 8'hAA);
        set_b(1'b1, 1'b1, 13'h0200, 8'hBB);
        tick();
        set_a(1'b1, 1'b0, 13'h0200, 8'h00);
        set_b(1'b1, 1'b0, 13'h0200, 8'h00);
        tick();
        check("dual_wr_a_wins_qa", q_a, 8'hAA);
        check("dual_wr_a_wins_qb", q_b, 8'hAA);
        set_a(1'b1, 1'b1, 13'h0300, 8'h01);
        set_b(1'b1, 1'b1, 13'h0301, 8'h02);
        tick();
        set_a(1'b1, 1'b0, 13'h0300, 8'h00);
        set_b(1'b1, 1'b0, 13'h0301, 8'h00);
        tick();
        check("dual_wr_diff_a", q_a, 8'h01);
        check("dual_wr_diff_b", q_b, 8'h02);

        // 6. Enable gating on port B at 0x1234; also port A holds while disabled.
        set_a(1'b1, 1'b0, 13'h0010, 8'h00);
        set_b(1'b1, 1'b0, 13'h1234, 8'h00);
        tick();
        check("gate_pre_qb", q_b, 8'h5A);
        check("gate_pre_qa", q_a, 8'h22);
        set_a(1'b0, 1'b0, 13'h0300, 8'h00);
        set_b(1'b0, 1'b1, 13'h1234, 8'h77);
        tick();
        check("gate_hold_qb", q_b, 8'h5A);
        check("gate_hold_qa", q_a, 8'h22);
        set_b(1'b1, 1'b0, 13'h1234, 8'h00);
        tick();
        check("gate_no_write", q_b, 8'h5A);

        // Top address written by B, read by A.
        set_b(1'b1, 1'b1, 13'h1FFF, 8'hC3);
        tick();
        set_b(1'b0, 1'b0, 13'h0000, 8'h00);
        set_a(1'b1, 1'b0, 13'h1FFF, 8'h00);
        tick();
        check("top_addr_a", q_a, 8'hC3);

        // Reset mid-run clears outputs, blocks writes, leaves storage intact.
        reset = 1'b1;
        set_a(1'b1, 1'b1, 13'h1234, 8'h99);
        set_b(1'b1, 1'b1, 13'h0010, 8'h98);
        tick();
        check("reset2_q_a", q_a, 8'h00);
        check("reset2_q_b", q_b, 8'h00);
        reset = 1'b0;
        set_a(1'b1, 1'b0, 13'h1234, 8'h00);
        set_b(1'b1, 1'b0, 13'h0010, 8'h00);
        tick();
        check("reset2_keep_a", q_a, 8'h5A);
        check("reset2_keep_b", q_b, 8'h22);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
